// File: rtl/matrix3_stream_sequencer_pkg.sv
// Shared definitions for the 3x3 neighbourhood sequencer: FSM state
// encodings, the fixed number of buffer row slots and slot arithmetic.
package matrix3_stream_sequencer_pkg;

  // The line buffer always rotates through three row slots.
  localparam int P_ROWS = 3;
  localparam int SLOT_W = 2;

  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [1:0]        state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_WRITE = 2'd1;
  localparam state_t S_READ  = 2'd2;
  localparam state_t S_EMIT  = 2'd3;

  // Next slot, wrapping modulo P_ROWS.
  function automatic slot_t slot_next(input slot_t s);
    return (s == slot_t'(P_ROWS - 1)) ? slot_t'(0) : s + slot_t'(1);
  endfunction

  // Previous slot, i.e. (s + 2) mod 3: the row above the one just written.
  function automatic slot_t slot_prev(input slot_t s);
    return (s == slot_t'(0)) ? slot_t'(P_ROWS - 1) : s - slot_t'(1);
  endfunction

  // Counter width for a range of v values, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/matrix3_stream_sequencer_if.sv
// Bundle of the pixel input stream, the line-buffer control bus and the
// matrix output handshake. The master modport is the sequencer's view;
// the slave modport is the surrounding stages (source, buffer, kernel).
interface matrix3_stream_sequencer_if #(
  parameter int P_COLUMNS     = 640,
  parameter int P_IMAGE_ROWS  = 480,
  parameter int P_PIXEL_DEPTH = 8
);
  import matrix3_stream_sequencer_pkg::*;

  localparam int COL_W = clog2_min1(P_COLUMNS);
  localparam int ROW_W = clog2_min1(P_IMAGE_ROWS);

  // Raster pixel input
  logic [P_PIXEL_DEPTH-1:0] pixel;
  logic                     pixel_valid;
  logic                     start_of_frame;
  logic                     pixel_ready;

  // Line buffer access
  logic [COL_W-1:0]         fb_column;
  slot_t                    fb_row;
  logic [P_PIXEL_DEPTH-1:0] fb_pixel;
  logic                     fb_write_enable;
  logic                     fb_read_enable;

  // Matrix hand-off to the edge kernel
  logic                     matrix_valid;
  logic                     matrix_ready;
  logic [COL_W-1:0]         center_column;
  logic [ROW_W-1:0]         center_row;
  logic                     frame_done;

  modport master (
    input  pixel, pixel_valid, start_of_frame, matrix_ready,
    output pixel_ready, fb_column, fb_row, fb_pixel, fb_write_enable,
           fb_read_enable, matrix_valid, center_column, center_row, frame_done
  );

  modport slave (
    output pixel, pixel_valid, start_of_frame, matrix_ready,
    input  pixel_ready, fb_column, fb_row, fb_pixel, fb_write_enable,
           fb_read_enable, matrix_valid, center_column, center_row, frame_done
  );

endinterface

// File: rtl/matrix3_stream_sequencer_raster_counter.sv
// Raster position tracker: column, image row and rotating buffer slot.
// Column wraps into a row increment; the last row wraps back to row 0 and
// slot 0 so every frame starts in the same slot. A synchronous clear
// restarts the frame and takes priority over advance.
module matrix3_stream_sequencer_raster_counter
  import matrix3_stream_sequencer_pkg::*;
#(
  parameter int P_COLUMNS    = 640,
  parameter int P_IMAGE_ROWS = 480,
  parameter int COL_W        = 10,
  parameter int ROW_W        = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output slot_t            slot
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(P_COLUMNS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(P_IMAGE_ROWS - 1);

  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;
  slot_t            slot_reg, slot_next_val;

  // Next raster position: clear, step one pixel, or hold.
  always_comb begin
    col_next      = col_reg;
    row_next      = row_reg;
    slot_next_val = slot_reg;
    if (clear) begin
      col_next      = '0;
      row_next      = '0;
      slot_next_val = '0;
    end else if (advance) begin
      if (col_reg == COL_LAST) begin
        col_next = '0;
        if (row_reg == ROW_LAST) begin
          row_next      = '0;
          slot_next_val = '0;
        end else begin
          row_next      = row_reg + ROW_W'(1);
          slot_next_val = slot_next(slot_reg);
        end
      end else begin
        col_next = col_reg + COL_W'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg  <= '0;
      row_reg  <= '0;
      slot_reg <= '0;
    end else begin
      col_reg  <= col_next;
      row_reg  <= row_next;
      slot_reg <= slot_next_val;
    end
  end

  assign col  = col_reg;
  assign row  = row_reg;
  assign slot = slot_reg;

endmodule

// File: rtl/matrix3_stream_sequencer.sv
// Raster-to-3x3 sequencer between the grayscale stage and the Sobel kernel.
// Each accepted pixel is written into its rotating row slot; once two rows
// and two columns of context exist, the neighbourhood centred one column
// and one row behind the write is read back and offered downstream.
// The buffer is single-ported, so write, read and emit take separate cycles.
module matrix3_stream_sequencer
  import matrix3_stream_sequencer_pkg::*;
#(
  parameter int P_COLUMNS     = 640,
  parameter int P_IMAGE_ROWS  = 480,
  parameter int P_PIXEL_DEPTH = 8
) (
  input logic                       clk,
  input logic                       rst,
  matrix3_stream_sequencer_if.master bus
);

  localparam int COL_W = clog2_min1(P_COLUMNS);
  localparam int ROW_W = clog2_min1(P_IMAGE_ROWS);
  // Images narrower or shorter than 3 have no interior pixels at all.
  localparam bit HAS_MATRIX = (P_COLUMNS >= 3) && (P_IMAGE_ROWS >= 3);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(P_COLUMNS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(P_IMAGE_ROWS - 1);

  state_t                   state_reg, state_next;
  logic                     started_reg;
  logic [P_PIXEL_DEPTH-1:0] pixel_reg;
  logic [COL_W-1:0]         wr_col_reg;
  logic [ROW_W-1:0]         wr_row_reg;
  slot_t                    wr_slot_reg;
  logic                     frame_done_reg;

  logic [COL_W-1:0]         cnt_col;
  logic [ROW_W-1:0]         cnt_row;
  slot_t                    cnt_slot;

  logic                     accepting;
  logic                     transfer;
  logic                     needs_read;
  logic                     last_pixel;
  logic                     done_event;

  // Ready is held low for the first cycle after reset release.
  assign accepting  = (state_reg == S_IDLE) && started_reg;
  assign transfer   = accepting && bus.pixel_valid;
  assign needs_read = HAS_MATRIX && (wr_row_reg >= ROW_W'(2)) && (wr_col_reg >= COL_W'(2));
  assign last_pixel = (wr_col_reg == COL_LAST) && (wr_row_reg == ROW_LAST);

  // The counters always describe the next pixel to arrive; a start of
  // frame clears them in the same cycle the pixel itself is latched as (0,0).
  matrix3_stream_sequencer_raster_counter #(
    .P_COLUMNS   (P_COLUMNS),
    .P_IMAGE_ROWS(P_IMAGE_ROWS),
    .COL_W       (COL_W),
    .ROW_W       (ROW_W)
  ) u_raster_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (transfer && bus.start_of_frame),
    .advance(state_reg == S_WRITE),
    .col    (cnt_col),
    .row    (cnt_row),
    .slot   (cnt_slot)
  );

  // Frame completion: after the last matrix is taken, or straight after the
  // last write when the image is too small to produce any matrix.
  generate
    if (HAS_MATRIX) begin : g_done_on_emit
      assign done_event = (state_reg == S_EMIT) && bus.matrix_ready && last_pixel;
    end else begin : g_done_on_write
      assign done_event = (state_reg == S_WRITE) && last_pixel;
    end
  endgenerate

  // Next-state decode: idle -> write -> (read -> emit) -> idle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (transfer) state_next = S_WRITE;
      S_WRITE: state_next = needs_read ? S_READ : S_IDLE;
      S_READ:  state_next = S_EMIT;
      S_EMIT:  if (bus.matrix_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State, start-up gating and frame-done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      started_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      started_reg    <= 1'b1;
      frame_done_reg <= done_event;
    end
  end

  // Capture the accepted pixel and the raster position it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_reg   <= '0;
      wr_col_reg  <= '0;
      wr_row_reg  <= '0;
      wr_slot_reg <= '0;
    end else if (transfer) begin
      pixel_reg   <= bus.pixel;
      wr_col_reg  <= bus.start_of_frame ? '0 : cnt_col;
      wr_row_reg  <= bus.start_of_frame ? '0 : cnt_row;
      wr_slot_reg <= bus.start_of_frame ? '0 : cnt_slot;
    end
  end

  // Buffer strobes, addresses and matrix handshake decoded from the state.
  always_comb begin
    bus.fb_column       = '0;
    bus.fb_row          = '0;
    bus.fb_write_enable = 1'b0;
    bus.fb_read_enable  = 1'b0;
    bus.matrix_valid    = 1'b0;
    bus.center_column   = '0;
    bus.center_row      = '0;
    case (state_reg)
      S_WRITE: begin
        bus.fb_write_enable = 1'b1;
        bus.fb_column       = wr_col_reg;
        bus.fb_row          = wr_slot_reg;
      end
      S_READ: begin
        // Centre sits one column left and one row up from the pixel just written.
        bus.fb_read_enable = 1'b1;
        bus.fb_column      = wr_col_reg - COL_W'(1);
        bus.fb_row         = slot_prev(wr_slot_reg);
        bus.center_column  = wr_col_reg - COL_W'(1);
        bus.center_row     = wr_row_reg - ROW_W'(1);
      end
      S_EMIT: begin
        bus.matrix_valid  = 1'b1;
        bus.center_column = wr_col_reg - COL_W'(1);
        bus.center_row    = wr_row_reg - ROW_W'(1);
      end
      default: ;
    endcase
  end

  assign bus.pixel_ready = accepting;
  assign bus.fb_pixel    = pixel_reg;
  assign bus.frame_done  = frame_done_reg;

endmodule

// File: tb/tb_matrix3_stream_sequencer.sv
// Bench for the 3x3 sequencer on a 4x4 image with a behavioural line buffer
// attached. A raster model predicts every buffer write and every matrix
// (centre and nine pixels) from the image itself; a per-cycle compare
// process checks the DUT against it, and directed literals pin key values.
module tb_matrix3_stream_sequencer;

  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix3_stream_sequencer_if #(.P_COLUMNS(W), .P_IMAGE_ROWS(H), .P_PIXEL_DEPTH(8)) bus ();

  matrix3_stream_sequencer #(.P_COLUMNS(W), .P_IMAGE_ROWS(H), .P_PIXEL_DEPTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Line buffer model: 3 row slots, registered 3x3 read around (column, slot).
  logic [7:0] fb_mem [0:2][0:W-1];
  logic [7:0] mat [0:8];
  always @(posedge clk) begin
    if (bus.fb_write_enable) fb_mem[bus.fb_row][bus.fb_column] <= bus.fb_pixel;
    if (bus.fb_read_enable)
      for (int i = 0; i < 3; i++)
        for (int k = 0; k < 3; k++)
          mat[i*3+k] <= fb_mem[(int'(bus.fb_row) + i + 2) % 3][int'(bus.fb_column) + k - 1];
  end

  // Raster model
  typedef struct packed { int col; int slot; int pix; } wr_t;
  typedef struct packed { int ccol; int crow; logic [8:0][7:0] v; logic last; } mat_t;

  wr_t  wr_q [$];
  mat_t mat_q [$];
  int   m_col = 0;
  int   m_row = 0;
  int   img [0:H-1][0:W-1];
  int   done_seen = 0;
  int   matrices_seen = 0;
  bit   done_pending = 1'b0;

  task automatic model_accept(input int pix, input bit sof);
    wr_t  w;
    mat_t m;
    if (sof) begin m_col = 0; m_row = 0; end
    w.col = m_col; w.slot = m_row % 3; w.pix = pix;
    wr_q.push_back(w);
    img[m_row][m_col] = pix;
    if (m_row >= 2 && m_col >= 2) begin
      m.ccol = m_col - 1;
      m.crow = m_row - 1;
      for (int i = 0; i < 3; i++)
        for (int k = 0; k < 3; k++)
          m.v[i*3+k] = 8'(img[m_row-2+i][m_col-2+k]);
      m.last = (m_col == W-1) && (m_row == H-1);
      mat_q.push_back(m);
    end
    if (m_col == W-1) begin
      m_col = 0;
      m_row = (m_row == H-1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    wr_t  w;
    mat_t m;
    if (rst) begin
      done_pending = 1'b0;
    end else begin
      check("strobe_exclusive", int'(bus.fb_write_enable & bus.fb_read_enable), 0);
      check("frame_done", int'(bus.frame_done), int'(done_pending));
      done_pending = 1'b0;
      if (bus.frame_done) done_seen++;
      if (bus.fb_write_enable) begin
        if (wr_q.size() == 0) flag("unexpected_write");
        else begin
          w = wr_q.pop_front();
          check("write_column", int'(bus.fb_column), w.col);
          check("write_slot", int'(bus.fb_row), w.slot);
          check("write_pixel", int'(bus.fb_pixel), w.pix);
        end
      end
      if (bus.matrix_valid) begin
        check("emit_ready_low", int'(bus.pixel_ready), 0);
        check("emit_no_strobe", int'(bus.fb_write_enable | bus.fb_read_enable), 0);
        if (mat_q.size() == 0) flag("unexpected_matrix");
        else begin
          m = mat_q[0];
          check("center_column", int'(bus.center_column), m.ccol);
          check("center_row", int'(bus.center_row), m.crow);
          for (int j = 0; j < 9; j++)
            check($sformatf("matrix_v%0d", j), int'(mat[j]), int'(m.v[j]));
          if (bus.matrix_ready) begin
            void'(mat_q.pop_front());
            matrices_seen++;
            if (m.last) done_pending = 1'b1;
          end
        end
      end
    end
  end

  task automatic send(input int pix, input bit sof);
    int t = 0;
    @(negedge clk);
    bus.pixel          = 8'(pix);
    bus.pixel_valid    = 1'b1;
    bus.start_of_frame = sof;
    while (!bus.pixel_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.pixel_ready) flag("send_timeout");
    else begin
      @(posedge clk);
      model_accept(pix, sof);
      #1;
    end
    bus.pixel_valid    = 1'b0;
    bus.start_of_frame = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_seen < target && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("frame_done_count", done_seen, target);
    check("matrices_pending", mat_q.size(), 0);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!bus.matrix_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("matrix_valid_seen", int'(bus.matrix_valid), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pixel          = '0;
    bus.pixel_valid    = 1'b0;
    bus.start_of_frame = 1'b0;
    bus.matrix_ready   = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", int'(bus.pixel_ready), 0);
    check("rst_valid", int'(bus.matrix_valid), 0);
    check("rst_write", int'(bus.fb_write_enable), 0);
    check("rst_read", int'(bus.fb_read_enable), 0);
    check("rst_done", int'(bus.frame_done), 0);
    check("rst_center_row", int'(bus.center_row), 0);
    rst = 1'b0;
    #1 check("ready_before_edge", int'(bus.pixel_ready), 0);
    @(posedge clk);
    #1 check("ready_after_edge", int'(bus.pixel_ready), 1);

    // Frame A: value = index, downstream always ready
    for (int i = 0; i < W*H; i++) begin
      send(i, i == 0);
      if (i == 10) begin
        @(posedge clk);
        #1;
        check("lat_valid_early", int'(bus.matrix_valid), 0);
        check("lat_read", int'(bus.fb_read_enable), 1);
        check("lat_read_column", int'(bus.fb_column), 1);
        check("lat_read_slot", int'(bus.fb_row), 1);
        @(posedge clk);
        #1;
        check("lat_valid", int'(bus.matrix_valid), 1);
        check("a_center_col", int'(bus.center_column), 1);
        check("a_center_row", int'(bus.center_row), 1);
        check("a_top_left", int'(mat[0]), 0);
        check("a_bottom_right", int'(mat[8]), 10);
      end
    end
    wait_done(1);
    check("a_matrices", matrices_seen, 4);

    // Frame B: backpressure on the first matrix for 5 cycles
    for (int i = 0; i < W*H; i++) begin
      if (i == 10) bus.matrix_ready = 1'b0;
      send(100 + i, i == 0);
      if (i == 10) begin
        wait_valid();
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("bp_valid_held", int'(bus.matrix_valid), 1);
          check("bp_center_col", int'(bus.center_column), 1);
          check("bp_center_row", int'(bus.center_row), 1);
          check("bp_top_left", int'(mat[0]), 100);
          check("bp_bottom_right", int'(mat[8]), 110);
        end
        @(posedge clk);
        #1 bus.matrix_ready = 1'b1;
      end
    end
    wait_done(2);
    check("b_matrices", matrices_seen, 8);

    // Frame C: start of frame at pixel 7 abandons the partial frame
    for (int i = 0; i < 7; i++) send(200 + i, i == 0);
    for (int i = 0; i < W*H; i++) begin
      send(50 + i, i == 0);
      if (i == 10) begin
        repeat (2) @(posedge clk);
        #1;
        check("c_center_col", int'(bus.center_column), 1);
        check("c_center_row", int'(bus.center_row), 1);
        check("c_top_left", int'(mat[0]), 50);
        check("c_bottom_right", int'(mat[8]), 60);
      end
    end
    wait_done(3);
    check("c_matrices", matrices_seen, 12);

    // Frame D: reset while a matrix is held in emit
    bus.matrix_ready = 1'b0;
    for (int i = 0; i <= 10; i++) send(30 + i, i == 0);
    wait_valid();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_emit_valid", int'(bus.matrix_valid), 0);
    check("rst_emit_ready", int'(bus.pixel_ready), 0);
    check("rst_emit_done", int'(bus.frame_done), 0);
    check("rst_emit_strobes", int'(bus.fb_write_enable | bus.fb_read_enable), 0);
    wr_q.delete();
    mat_q.delete();
    m_col = 0;
    m_row = 0;
    bus.matrix_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < W*H; i++) send(80 + i, i == 0);
    wait_done(4);
    check("total_matrices", matrices_seen, 16);

    repeat (5) @(negedge clk);
    check("final_done_count", done_seen, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
